digit_scan_sequencer: RTL

Upstream driver for `two_to_four_and_decoder`. Generates the 2-bit select pair `A`/`B` at a programmable rate so the decoder's one-hot outputs `D0..D3` sweep through all four lines, as in digit scanning on the lab board. Supports free-running scan, single-step, and up/down direction. A compile-time option inserts blanking gaps between select changes.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/scan_tick_divider.sv | 36 +++
 rtl/digit_scan_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan sequencer and its divider.
package scan_pkg;

  localparam int SCAN_IDX_W = 2;

  localparam logic SCAN_DIR_UP   = 1'b0;
  localparam logic SCAN_DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  // Modulo-4 step of the scan index in the requested direction.
  function automatic logic [SCAN_IDX_W-1:0] scan_next_idx(
    input logic [SCAN_IDX_W-1:0] idx,
    input logic                  dir
  );
    return (dir == SCAN_DIR_UP) ? idx + SCAN_IDX_W'(1) : idx - SCAN_IDX_W'(1);
  endfunction

endpackage

// File: rtl/scan_tick_divider.sv
// Dwell counter with clear/enable; flags terminal count when the count reaches the limit.
module scan_tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] limit,
  output logic                 term
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so a limit lowered mid-dwell still terminates next edge.
  assign term = (cnt_q >= limit);

endmodule

// File: rtl/digit_scan_sequencer.sv
// Scan sequencer driving the A/B select pair of a 2-to-4 decoder.
// Optional blanking between select changes is enabled with `define SCAN_BLANK_EN.
module digit_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 dir,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 A,
  output logic                 B,
  output logic                 tick,
  output logic                 blank
);

  // The divider counts the blank gap too, so its limit switches in BLANK.
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);

  scan_state_e           state_q, state_d;
  logic [SCAN_IDX_W-1:0] idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic                  cnt_clr, cnt_en, term;
  logic [DIV_WIDTH-1:0]  limit;

  assign limit = (state_q == BLANK) ? BLANK_LAST : div;

  scan_tick_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (limit),
    .term   (term)
  );

`ifdef SCAN_BLANK_EN
  logic blank_q, blank_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
        end else if (step) begin
          idx_d  = scan_next_idx(idx_q, dir);
          tick_d = 1'b1;
        end
      end
      RUN: begin
        // A falling run beats a coincident terminal count.
        if (!run) begin
          state_d = IDLE;
        end else if (term) begin
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
          blank_d = 1'b1;
`else
          idx_d  = scan_next_idx(idx_q, dir);
          tick_d = 1'b1;
`endif
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (!run) begin
          state_d = IDLE;
        end else if (term) begin
          state_d = RUN;
          idx_d   = scan_next_idx(idx_q, dir);
          tick_d  = 1'b1;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          blank_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

`ifdef SCAN_BLANK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign A    = idx_q[1];
  assign B    = idx_q[0];
  assign tick = tick_q;

endmodule
